latency_pipe_credit_sink: RTL

- Sits directly downstream of the N-stage latency pipe in the ASE response path.
- Catches every {valid, data} word the pipe emits. The pipe cannot stall, so the block buffers each word in a FIFO and presents it to the consumer over a valid/ready handshake.
- Owns the credit counter that gates launches into the pipe, so the FIFO can never overflow regardless of pipe depth.

---
 rtl/latency_pipe_credit_sink.sv | 110 +++++++++++
 1 files changed

// File: rtl/latency_pipe_credit_sink.sv
// Credit-gated sink behind a non-stallable latency pipe. Every word the pipe
// emits is buffered in a small FIFO and then offered to the consumer over a
// valid/ready handshake. The credit counter limits launches into the pipe so
// the number of in-flight plus buffered words can never exceed DEPTH.
module latency_pipe_credit_sink #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid,
  output logic                  credit_avail,
  input  logic                  pipe_valid,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [CNT_W-1:0]      credits,
  output logic                  launch_err,
  output logic                  overflow_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      credits_q, credits_d;
  logic                  launch_err_q, launch_err_d;
  logic                  overflow_err_q, overflow_err_d;

  logic launch, pop, full, push_acc;

  // Per-cycle events; a full FIFO still accepts a push when the head leaves.
  always_comb begin
    credit_avail = (credits_q != '0);
    out_valid    = (count_q != '0);
    full         = (count_q == DepthCnt);
    launch       = launch_valid & credit_avail;
    pop          = out_valid & out_ready;
    push_acc     = pipe_valid & (~full | pop);
  end

  // Next-state for credits, occupancy, pointers and sticky errors.
  always_comb begin
    credits_d = credits_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    // Saturate so a bypassed push (not backed by a credit) cannot wrap credits.
    if (launch && !pop) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!launch && pop && (credits_q != DepthCnt)) begin
      credits_d = credits_q + CNT_W'(1);
    end
    if (push_acc && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    launch_err_d   = launch_err_q | (launch_valid & ~credit_avail);
    overflow_err_d = overflow_err_q | (pipe_valid & full & ~pop);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q      <= DepthCnt;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      launch_err_q   <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      launch_err_q   <= launch_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Storage is never reset; out_data masking hides stale contents.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= pipe_data;
    end
  end

  // Head presentation, forced to zero when empty so no X leaks downstream.
  always_comb begin
    out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    fifo_count   = count_q;
    credits      = credits_q;
    launch_err   = launch_err_q;
    overflow_err = overflow_err_q;
  end

endmodule
